// File: rtl/mem_arb_defs_pkg.sv
// Shared encodings for the unified memory-port arbiter: FSM states and
// request-owner tags.
package mem_arb_defs;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2,
    RESP = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/mem_arb_starve.sv
// Fetch-starvation counter: counts data grants taken while a fetch waits and
// flags when the limit is reached. Used only when MEM_ARB_FAIR_EN is defined.
module mem_arb_starve #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic hit
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(LIMIT);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != LIM)) begin
      count <= count + 1'b1;
    end
  end

  assign hit = (count == LIM);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, data first.
// Optional fetch anti-starvation is enabled by defining MEM_ARB_FAIR_EN.
module mem_port_arbiter
  import mem_arb_defs::*;
#(
  parameter int WIDTH        = 32,
  parameter int ADRWIDTH     = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                iread,
  input  logic [ADRWIDTH-1:0] iadr,
  output logic [WIDTH-1:0]    irdata,
  output logic                iready,
  input  logic                dread,
  input  logic                dwrite,
  input  logic [ADRWIDTH-1:0] dadr,
  input  logic [WIDTH-1:0]    dwdata,
  output logic [WIDTH-1:0]    drdata,
  output logic                dready,
  output logic [ADRWIDTH-1:0] memadr,
  output logic [WIDTH-1:0]    memwdata,
  output logic                memread,
  output logic                memwrite,
  input  logic [WIDTH-1:0]    memrdata,
  input  logic                memready
);

  arb_state_t state, state_next;
  arb_owner_t winner;
  logic       grant;
  logic       dreq;
  logic       starve_hit;

  assign dreq = dread | dwrite;

  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("STARVE_LIMIT must be at least 1");
  end

`ifdef MEM_ARB_FAIR_EN
  mem_arb_starve #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk  (clk),
    .reset(reset),
    .clr  (grant && (winner == OWN_I)),
    .inc  (grant && (winner == OWN_D) && iread),
    .hit  (starve_hit)
  );
`else
  assign starve_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A starved fetch only overrides data priority when both sides are asking.
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    winner     = OWN_D;
    unique case (state)
      IDLE: begin
        if (dreq && !(iread && starve_hit)) begin
          grant      = 1'b1;
          winner     = OWN_D;
          state_next = DGNT;
        end else if (iread) begin
          grant      = 1'b1;
          winner     = OWN_I;
          state_next = IGNT;
        end
      end
      IGNT, DGNT: begin
        if (memready) begin
          state_next = RESP;
        end
      end
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Command is captured on grant and held until memory completes; a write
  // wins over a read when both are raised together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      memadr   <= '0;
      memwdata <= '0;
      memread  <= 1'b0;
      memwrite <= 1'b0;
      irdata   <= '0;
      drdata   <= '0;
      iready   <= 1'b0;
      dready   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant) begin
            if (winner == OWN_D) begin
              memadr   <= dadr;
              memwdata <= dwdata;
              memwrite <= dwrite;
              memread  <= ~dwrite;
            end else begin
              memadr   <= iadr;
              memwdata <= '0;
              memread  <= 1'b1;
              memwrite <= 1'b0;
            end
          end
        end
        IGNT: begin
          if (memready) begin
            memread  <= 1'b0;
            memwrite <= 1'b0;
            irdata   <= memrdata;
            iready   <= 1'b1;
          end
        end
        DGNT: begin
          if (memready) begin
            memread  <= 1'b0;
            memwrite <= 1'b0;
            drdata   <= memwrite ? '0 : memrdata;
            dready   <= 1'b1;
          end
        end
        RESP: begin
          iready <= 1'b0;
          dready <= 1'b0;
        end
        default: begin
          iready <= 1'b0;
          dready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural memory responder.
// Expected grant order under contention follows MEM_ARB_FAIR_EN.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        iread = 1'b0;
  logic [31:0] iadr = '0;
  logic [31:0] irdata;
  logic        iready;
  logic        dread = 1'b0;
  logic        dwrite = 1'b0;
  logic [31:0] dadr = '0;
  logic [31:0] dwdata = '0;
  logic [31:0] drdata;
  logic        dready;
  logic [31:0] memadr;
  logic [31:0] memwdata;
  logic        memread;
  logic        memwrite;
  logic [31:0] memrdata = '0;
  logic        memready = 1'b0;

  mem_port_arbiter #(
    .WIDTH(32), .ADRWIDTH(32), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .reset(reset),
    .iread(iread), .iadr(iadr), .irdata(irdata), .iready(iready),
    .dread(dread), .dwrite(dwrite), .dadr(dadr), .dwdata(dwdata),
    .drdata(drdata), .dready(dready),
    .memadr(memadr), .memwdata(memwdata), .memread(memread),
    .memwrite(memwrite), .memrdata(memrdata), .memready(memready)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] adr;
    bit          wr;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct {
    bit          side;
    logic [31:0] rdata;
  } rsp_t;

  cmd_t        cmd_q[$];
  rsp_t        rsp_q[$];
  logic [31:0] model[logic [31:0]];
  int          cur_wait = 0;
  bit          abandon = 1'b0;

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (model.exists(a)) return model[a];
    return a ^ 32'h5a5a0000;
  endfunction

  function automatic void exp_fetch(input logic [31:0] a);
    cmd_q.push_back('{adr: a, wr: 1'b0, wdata: 32'h0});
    rsp_q.push_back('{side: 1'b0, rdata: model_rd(a)});
  endfunction

  function automatic void exp_load(input logic [31:0] a);
    cmd_q.push_back('{adr: a, wr: 1'b0, wdata: 32'h0});
    rsp_q.push_back('{side: 1'b1, rdata: model_rd(a)});
  endfunction

  function automatic void exp_store(input logic [31:0] a, input logic [31:0] d);
    cmd_q.push_back('{adr: a, wr: 1'b1, wdata: d});
    rsp_q.push_back('{side: 1'b1, rdata: 32'h0});
  endfunction

  // Memory responder: acknowledges after cur_wait stall cycles.
  initial begin
    int cnt = 0;
    forever begin
      @(negedge clk);
      if (memread || memwrite) begin
        if (cnt == cur_wait) begin
          memready = 1'b1;
          if (memwrite) begin
            model[memadr] = memwdata;
            memrdata = 32'hbad0bad0;
          end else begin
            memrdata = model_rd(memadr);
          end
          cnt = 0;
        end else begin
          memready = 1'b0;
          memrdata = $urandom;
          cnt++;
        end
      end else begin
        memready = 1'b0;
        memrdata = $urandom;
        cnt = 0;
      end
    end
  end

  // Monitor: command stream, response latency and response scoreboard.
  initial begin
    bit   prev_strobe = 1'b0;
    int   len = 0;
    bit   ack;
    rsp_t r;
    forever begin
      @(posedge clk);
      ack = memready && (memread || memwrite);
      #1;
      if (memread || memwrite) begin
        len++;
        chk_eq("rw_excl", 32'(memread && memwrite), 32'h0);
        if (cmd_q.size() == 0) begin
          chk_eq("cmd_unexp", 32'h1, 32'h0);
        end else begin
          chk_eq("cmd_adr", memadr, cmd_q[0].adr);
          chk_eq("cmd_wr", 32'(memwrite), 32'(cmd_q[0].wr));
          chk_eq("cmd_rd", 32'(memread), 32'(!cmd_q[0].wr));
          if (cmd_q[0].wr) chk_eq("cmd_wdata", memwdata, cmd_q[0].wdata);
        end
      end else if (prev_strobe) begin
        if (cmd_q.size() > 0) void'(cmd_q.pop_front());
        if (!abandon) chk_eq("strobe_len", 32'(len), 32'(cur_wait + 1));
        len = 0;
      end
      prev_strobe = memread || memwrite;
      if (iready || dready || ack) chk_eq("ready_lat", 32'(iready || dready), 32'(ack));
      if (iready || dready) begin
        chk_eq("ready_excl", 32'(iready && dready), 32'h0);
        if (rsp_q.size() == 0) begin
          chk_eq("rsp_unexp", 32'h1, 32'h0);
        end else begin
          r = rsp_q.pop_front();
          chk_eq("rsp_side", 32'(dready), 32'(r.side));
          chk_eq("rsp_data", dready ? drdata : irdata, r.rdata);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a, output int n);
    iread = 1'b1;
    iadr  = a;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!iready && n < 300);
    if (!iready) chk_eq("i_timeout", 32'h0, 32'h1);
    iread = 1'b0;
  endtask

  task automatic dacc(input bit rd, input bit wr, input logic [31:0] a,
                      input logic [31:0] d, output int n);
    dread  = rd;
    dwrite = wr;
    dadr   = a;
    dwdata = d;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!dready && n < 300);
    if (!dready) chk_eq("d_timeout", 32'h0, 32'h1);
    dread  = 1'b0;
    dwrite = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int n2;
    model[32'h0]  = 32'h20020005;
    model[32'h2c] = 32'h9;

    // Reset state.
    idle(3);
    chk_eq("rst_memadr", memadr, 32'h0);
    chk_eq("rst_memwdata", memwdata, 32'h0);
    chk_eq("rst_memread", 32'(memread), 32'h0);
    chk_eq("rst_memwrite", 32'(memwrite), 32'h0);
    chk_eq("rst_iready", 32'(iready), 32'h0);
    chk_eq("rst_dready", 32'(dready), 32'h0);
    chk_eq("rst_irdata", irdata, 32'h0);
    chk_eq("rst_drdata", drdata, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    idle(2);

    // Single fetch, minimum latency.
    exp_fetch(32'h0);
    fetch(32'h0, n);
    chk_eq("fetch_lat", 32'(n), 32'd2);
    idle(2);

    // Store, then load it back.
    exp_store(32'h54, 32'h7);
    dacc(1'b0, 1'b1, 32'h54, 32'h7, n);
    chk_eq("store_lat", 32'(n), 32'd2);
    idle(1);
    exp_load(32'h54);
    dacc(1'b1, 1'b0, 32'h54, 32'h0, n);
    idle(2);

    // Contention: data wins.
    exp_load(32'h12);
    exp_fetch(32'h8);
    fork
      fetch(32'h8, n);
      dacc(1'b1, 1'b0, 32'h12, 32'h0, n2);
    join
    chk_eq("cont_order", 32'(n > n2), 32'h1);
    idle(2);

    // Wait states on a load.
    cur_wait = 5;
    exp_load(32'h2c);
    dacc(1'b1, 1'b0, 32'h2c, 32'h0, n);
    chk_eq("wait_lat", 32'(n), 32'd7);
    idle(2);
    cur_wait = 0;

    // Read and write together: treated as a write.
    exp_store(32'h60, 32'hdead);
    dacc(1'b1, 1'b1, 32'h60, 32'hdead, n);
    idle(2);

    // Fetch request dropped while granted still completes.
    exp_fetch(32'h44);
    iread = 1'b1;
    iadr  = 32'h44;
    idle(1);
    iread = 1'b0;
    n = 0;
    while (!iready && n < 20) begin
      idle(1);
      n++;
    end
    chk_eq("drop_ready", 32'(iready), 32'h1);
    idle(2);

    // Reset mid-transaction.
    cur_wait = 20;
    abandon  = 1'b1;
    cmd_q.push_back('{adr: 32'h40, wr: 1'b1, wdata: 32'h55});
    dwrite = 1'b1;
    dadr   = 32'h40;
    dwdata = 32'h55;
    n = 0;
    while (!memwrite && n < 10) begin
      idle(1);
      n++;
    end
    chk_eq("rst_pre_wr", 32'(memwrite), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk_eq("arst_memwrite", 32'(memwrite), 32'h0);
    chk_eq("arst_memadr", memadr, 32'h0);
    chk_eq("arst_memwdata", memwdata, 32'h0);
    chk_eq("arst_irdata", irdata, 32'h0);
    chk_eq("arst_drdata", drdata, 32'h0);
    dwrite = 1'b0;
    iread  = 1'b1;
    iadr   = 32'h8;
    @(posedge clk);
    #2;
    abandon = 1'b0;
    chk_eq("rst_hold", 32'(memread), 32'h0);
    cur_wait = 0;
    @(negedge clk);
    reset = 1'b1;
    exp_fetch(32'h8);
    fetch(32'h8, n);
    idle(2);

    // Sustained contention: 10 loads, 2 fetches.
`ifdef MEM_ARB_FAIR_EN
    for (int i = 0; i < 4; i++) exp_load(32'h200 + 32'(4 * i));
    exp_fetch(32'h300);
    for (int i = 4; i < 8; i++) exp_load(32'h200 + 32'(4 * i));
    exp_fetch(32'h304);
    for (int i = 8; i < 10; i++) exp_load(32'h200 + 32'(4 * i));
`else
    for (int i = 0; i < 10; i++) exp_load(32'h200 + 32'(4 * i));
    exp_fetch(32'h300);
    exp_fetch(32'h304);
`endif
    fork
      begin
        int m;
        fetch(32'h300, m);
        fetch(32'h304, m);
      end
      begin
        int m;
        for (int i = 0; i < 10; i++) dacc(1'b1, 1'b0, 32'h200 + 32'(4 * i), 32'h0, m);
      end
    join
    idle(3);

    chk_eq("cmd_q_empty", 32'(cmd_q.size()), 32'h0);
    chk_eq("rsp_q_empty", 32'(rsp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
